// File: rtl/maindec_mc.sv
// Multicycle main decoder: latches an opcode, walks DECODE/EXEC/MEM/WB and
// drives per-phase datapath controls, with a saturating retired-instruction count.
module maindec_mc #(
  parameter int OPW     = 11,
  parameter int CNTW    = 16,
  parameter int EN_CBNZ = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [OPW-1:0]  Op,
  input  logic            mem_ready,
  output logic            Reg2Loc,
  output logic            ALUSrc,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic            BrInv,
  output logic [1:0]      ALUOp,
  output logic            done,
  output logic            illegal,
  output logic [CNTW-1:0] instr_count,
  output logic [2:0]      fsm_state
);

  // Handshake: an opcode transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr_ready is 1 only in IDLE, so valid is ignored elsewhere.

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {C_ILL, C_R, C_LD, C_ST, C_CBZ, C_CBNZ} cls_t;

  state_t      state, state_nxt;
  cls_t        cls;
  logic [10:0] op_q;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_q        <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid)
        op_q <= Op[OPW-1 -: 11];
      if (done && instr_count != '1)
        instr_count <= instr_count + CNTW'(1);
    end
  end

  // Class is derived from the latched opcode only, so outputs never follow Op mid-instruction.
  always_comb begin
    cls = C_ILL;
    casez (op_q)
      11'b11111000010: cls = C_LD;
      11'b11111000000: cls = C_ST;
      11'b10110100???: cls = C_CBZ;
      11'b10110101???: cls = (EN_CBNZ != 0) ? C_CBNZ : C_ILL;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls = C_R;
      default:         cls = C_ILL;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    Reg2Loc     = 1'b0;
    ALUSrc      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Branch      = 1'b0;
    BrInv       = 1'b0;
    ALUOp       = 2'b00;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (cls == C_ILL) begin
          illegal   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        case (cls)
          C_R: begin
            ALUOp     = 2'b10;
            state_nxt = WB;
          end
          C_LD: begin
            ALUSrc    = 1'b1;
            state_nxt = MEM;
          end
          C_ST: begin
            ALUSrc    = 1'b1;
            Reg2Loc   = 1'b1;
            state_nxt = MEM;
          end
          C_CBZ, C_CBNZ: begin
            Reg2Loc   = 1'b1;
            ALUOp     = 2'b01;
            Branch    = 1'b1;
            BrInv     = (cls == C_CBNZ);
            done      = 1'b1;
            state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
      MEM: begin
        // Memory controls hold until the memory completes; there is no timeout.
        ALUSrc = 1'b1;
        if (cls == C_ST) begin
          Reg2Loc  = 1'b1;
          MemWrite = 1'b1;
        end else begin
          MemRead = 1'b1;
        end
        if (mem_ready) begin
          if (cls == C_ST) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        MemtoReg  = (cls == C_LD);
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
